// File: rtl/arb_pkg.sv
// Shared definitions for the parametrised priority arbiter: scheme encodings and FSM states.
package arb_pkg;

    localparam int unsigned ARB_FIXED = 0;
    localparam int unsigned ARB_RR    = 1;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational picker: descending search over (req & mask) starting at start_idx, wrapping
// from 0 back to N-1. Returns the first eligible index as one-hot and encoded form.
module arb_prio_pick
    import arb_pkg::*;
#(
    parameter  int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start_idx,
    output logic [N-1:0] pick,
    output logic [W-1:0] pick_idx,
    output logic         found
);

    logic [N-1:0] cand;
    logic [W-1:0] idx;

    always_comb begin
        cand     = req & mask;
        found    = 1'b0;
        pick_idx = '0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = W'((32'(start_idx) + N - 32'(k)) % N);
            if (!found && cand[idx]) begin
                found    = 1'b1;
                pick_idx = idx;
            end
        end
        pick = found ? (N'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/priority_arbiter_param.sv
// N-way arbiter with fixed-priority or round-robin selection, grant hold while requesting,
// and an optional hold limit. All outputs come straight from registers.
module priority_arbiter_param
    import arb_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned RR_MODE  = ARB_FIXED,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_valid
);

    // With MAX_HOLD=0 the counter only needs to saturate at 1; the limit is never applied.
    localparam int unsigned HoldMax = (MAX_HOLD > 0) ? MAX_HOLD : 1;
    localparam int unsigned HW      = $clog2(HoldMax + 1);

    arb_state_e    state_q, state_d;
    logic [W-1:0]  owner_q, owner_d;
    logic [W-1:0]  last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;

    logic [N-1:0]  owner_oh, pick_mask, pick;
    logic [W-1:0]  start_idx, pick_idx;
    logic          found, own_req, others, limit;

    always_comb begin
        owner_oh  = N'(1) << owner_q;
        own_req   = (state_q == ARB_BUSY) && req[owner_q];
        others    = |(req & ~owner_oh);
        limit     = (MAX_HOLD > 0) && own_req && others && (hold_q == HW'(HoldMax));
        pick_mask = limit ? ~owner_oh : '1;
        if (RR_MODE == ARB_RR) begin
            start_idx = (last_q == '0) ? W'(N - 1) : last_q - 1'b1;
        end else begin
            start_idx = W'(N - 1);
        end
    end

    arb_prio_pick #(
        .N (N)
    ) u_pick (
        .req       (req),
        .mask      (pick_mask),
        .start_idx (start_idx),
        .pick      (pick),
        .pick_idx  (pick_idx),
        .found     (found)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_BUSY;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = HW'(1);
                    gnt_d   = pick;
                end
            end
            ARB_BUSY: begin
                if (own_req && !limit) begin
                    if (hold_q != HW'(HoldMax)) hold_d = hold_q + 1'b1;
                end else if (found) begin
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    hold_d  = HW'(1);
                    gnt_d   = pick;
                end else begin
                    state_d = ARB_IDLE;
                    owner_d = '0;
                    hold_d  = '0;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = '0;
                hold_d  = '0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            last_q  <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = owner_q;
    assign gnt_valid = (state_q == ARB_BUSY);

endmodule

// File: tb/tb_priority_arbiter_param.sv
// Bench for priority_arbiter_param: three configurations (fixed, round-robin, fixed with hold 3)
// driven per scenario, expected grants queued at drive time and compared after the edge.
module tb_priority_arbiter_param;

    localparam int DutFix  = 0;
    localparam int DutRr   = 1;
    localparam int DutHold = 2;

    typedef struct {
        int         dut;
        logic [3:0] gnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req_fix, req_rr, req_hold;
    logic [3:0] gnt_fix, gnt_rr, gnt_hold;
    logic [1:0] idx_fix, idx_rr, idx_hold;
    logic       vld_fix, vld_rr, vld_hold;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    priority_arbiter_param #(.N(4), .RR_MODE(0), .MAX_HOLD(0)) u_fix (
        .clk (clk), .rst (rst), .req (req_fix),
        .gnt (gnt_fix), .gnt_idx (idx_fix), .gnt_valid (vld_fix)
    );

    priority_arbiter_param #(.N(4), .RR_MODE(1), .MAX_HOLD(0)) u_rr (
        .clk (clk), .rst (rst), .req (req_rr),
        .gnt (gnt_rr), .gnt_idx (idx_rr), .gnt_valid (vld_rr)
    );

    priority_arbiter_param #(.N(4), .RR_MODE(0), .MAX_HOLD(3)) u_hold (
        .clk (clk), .rst (rst), .req (req_hold),
        .gnt (gnt_hold), .gnt_idx (idx_hold), .gnt_valid (vld_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] exp_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [6:0] observe(input int dut);
        case (dut)
            DutFix:  return {gnt_fix, idx_fix, vld_fix};
            DutRr:   return {gnt_rr, idx_rr, vld_rr};
            default: return {gnt_hold, idx_hold, vld_hold};
        endcase
    endfunction

    // Drive one cycle of stimulus on the chosen instance and queue its expected grant.
    task automatic apply(input int dut, input logic r, input logic [3:0] rq,
                         input logic [3:0] eg);
        exp_t e;
        rst      = r;
        req_fix  = (dut == DutFix)  ? rq : 4'b0000;
        req_rr   = (dut == DutRr)   ? rq : 4'b0000;
        req_hold = (dut == DutHold) ? rq : 4'b0000;
        e.dut = dut;
        e.gnt = eg;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic       r;
        logic [3:0] rq, eg;
        exp_t       e;
        logic [6:0] obs, want;
        for (int i = 0; i < 5; i++) begin
            r  = (i < 3);
            rq = (i < 4) ? 4'b1111 : 4'b0000;
            eg = (i == 3) ? 4'b1000 : 4'b0000;
            apply(DutFix, r, rq, eg);
            e    = sb.pop_front();
            obs  = observe(e.dut);
            want = {e.gnt, exp_idx(e.gnt), |e.gnt};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset step %0d: got gnt/idx/valid=%b/%0d/%b want %b/%0d/%b",
                         i, obs[6:3], obs[2:1], obs[0], want[6:3], want[2:1], want[0]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] rq, eg;
        exp_t       e;
        logic [6:0] obs, want;
        for (int i = 0; i < 22; i++) begin
            rq = (i < 20) ? 4'b0110 : (i == 20) ? 4'b0010 : 4'b0000;
            eg = (i < 20) ? 4'b0100 : rq;
            apply(DutFix, 1'b0, rq, eg);
            e    = sb.pop_front();
            obs  = observe(e.dut);
            want = {e.gnt, exp_idx(e.gnt), |e.gnt};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL fixed_priority step %0d: got gnt/idx/valid=%b/%0d/%b want %b/%0d/%b",
                         i, obs[6:3], obs[2:1], obs[0], want[6:3], want[2:1], want[0]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] rq_t[8] = '{4'b1111, 4'b0111, 4'b1011, 4'b1101,
                                4'b1110, 4'b0000, 4'b1001, 4'b0000};
        logic [3:0] eg_t[8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001,
                                4'b1000, 4'b0000, 4'b0001, 4'b0000};
        exp_t       e;
        logic [6:0] obs, want;
        for (int i = 0; i < 8; i++) begin
            apply(DutRr, 1'b0, rq_t[i], eg_t[i]);
            e    = sb.pop_front();
            obs  = observe(e.dut);
            want = {e.gnt, exp_idx(e.gnt), |e.gnt};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL round_robin step %0d: got gnt/idx/valid=%b/%0d/%b want %b/%0d/%b",
                         i, obs[6:3], obs[2:1], obs[0], want[6:3], want[2:1], want[0]);
            end
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] rq, eg;
        exp_t       e;
        logic [6:0] obs, want;
        for (int i = 0; i < 22; i++) begin
            if (i < 10) begin
                rq = 4'b1001;
                eg = (i < 3 || (i >= 6 && i < 9)) ? 4'b1000 : 4'b0001;
            end else if (i < 20) begin
                rq = 4'b1000;
                eg = 4'b1000;
            end else if (i == 20) begin
                // Counter is already saturated, so a new competitor takes over immediately.
                rq = 4'b1001;
                eg = 4'b0001;
            end else begin
                rq = 4'b0000;
                eg = 4'b0000;
            end
            apply(DutHold, 1'b0, rq, eg);
            e    = sb.pop_front();
            obs  = observe(e.dut);
            want = {e.gnt, exp_idx(e.gnt), |e.gnt};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL hold_limit step %0d: got gnt/idx/valid=%b/%0d/%b want %b/%0d/%b",
                         i, obs[6:3], obs[2:1], obs[0], want[6:3], want[2:1], want[0]);
            end
        end
    endtask

    task automatic test_idle_pulse();
        logic [3:0] rq_t[5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        exp_t       e;
        logic [6:0] obs, want;
        for (int i = 0; i < 5; i++) begin
            apply(DutFix, 1'b0, rq_t[i], rq_t[i]);
            e    = sb.pop_front();
            obs  = observe(e.dut);
            want = {e.gnt, exp_idx(e.gnt), |e.gnt};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL idle_pulse step %0d: got gnt/idx/valid=%b/%0d/%b want %b/%0d/%b",
                         i, obs[6:3], obs[2:1], obs[0], want[6:3], want[2:1], want[0]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic       r_t[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] rq_t[5] = '{4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
        logic [3:0] eg_t[5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
        exp_t       e;
        logic [6:0] obs, want;
        for (int i = 0; i < 5; i++) begin
            apply(DutRr, r_t[i], rq_t[i], eg_t[i]);
            e    = sb.pop_front();
            obs  = observe(e.dut);
            want = {e.gnt, exp_idx(e.gnt), |e.gnt};
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_mid_grant step %0d: got gnt/idx/valid=%b/%0d/%b want %b/%0d/%b",
                         i, obs[6:3], obs[2:1], obs[0], want[6:3], want[2:1], want[0]);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        req_fix  = 4'b0000;
        req_rr   = 4'b0000;
        req_hold = 4'b0000;
        @(posedge clk);
        #1;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_hold_limit();
        test_idle_pulse();
        test_reset_mid_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
